// File: rtl/i2c_tmp100_slave.sv
// I2C responder modelling the TMP100 register map: address match, pointer,
// temperature (fabric supplied), configuration, T_LOW and T_HIGH.
module i2c_tmp100_slave #(
    parameter logic [6:0] G_ADDR      = 7'h48,
    parameter logic [7:0] G_CFG_RESET = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl,
    inout  wire         io_sda,
    input  logic [11:0] i_temperature,
    output logic [7:0]  o_config,
    output logic        o_busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    state_t      state_q, state_n;
    logic        scl_p0, scl_p1, scl_p2;
    logic        sda_p0, sda_p1, sda_p2;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic        ack_ph_q;
    logic        rw_q;
    logic [1:0]  ptr_q;
    logic        byte_idx_q;
    logic [7:0]  cfg_q;
    logic [15:0] tlow_q, thigh_q;
    logic [11:0] shadow_q;
    logic        sda_oe_q;
    logic        busy_q;

    logic        start_det, stop_det, scl_rise, scl_fall;
    logic        last_bit, addr_hit;
    logic [7:0]  byte_in, tx_byte;

    function automatic logic [7:0] rd_byte(input logic [1:0] ptr, input logic idx,
                                           input logic [11:0] t, input logic [7:0] cfg,
                                           input logic [15:0] tl, input logic [15:0] th);
        logic [7:0] b;
        case (ptr)
            2'd0:    b = idx ? {t[3:0], 4'h0} : t[11:4];
            2'd1:    b = cfg;
            2'd2:    b = idx ? tl[7:0] : tl[15:8];
            default: b = idx ? th[7:0] : th[15:8];
        endcase
        return b;
    endfunction

    // Synchronizer (p0, p1) and one-cycle history (p2); idle bus reads high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {scl_p0, scl_p1, scl_p2} <= 3'b111;
            {sda_p0, sda_p1, sda_p2} <= 3'b111;
        end else begin
            scl_p0 <= i_scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= io_sda;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign byte_in   = {shreg_q[6:0], sda_p1};
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign addr_hit  = (byte_in[7:1] == G_ADDR);
    assign tx_byte   = rd_byte(ptr_q, byte_idx_q, shadow_q, cfg_q, tlow_q, thigh_q);

    always_comb begin
        state_n = state_q;
        if (stop_det) begin
            state_n = S_IDLE;
        end else if (start_det) begin
            state_n = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:      if (scl_rise && last_bit) state_n = addr_hit ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  if (scl_fall && ack_ph_q) state_n = rw_q ? S_RDATA : S_PTR;
                S_PTR:       if (scl_rise && last_bit) state_n = S_PTR_ACK;
                S_PTR_ACK:   if (scl_fall && ack_ph_q) state_n = S_WDATA;
                S_WDATA:     if (scl_rise && last_bit) state_n = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && ack_ph_q) state_n = S_WDATA;
                S_RDATA:     if (scl_rise && last_bit) state_n = S_RACK;
                S_RACK: begin
                    if (scl_rise && sda_p1)        state_n = S_IGNORE;
                    else if (scl_fall && ack_ph_q) state_n = S_RDATA;
                end
                S_IDLE, S_IGNORE: state_n = state_q;
                default:          state_n = S_IDLE;
            endcase
        end
    end

    // Byte engine: ack_ph_q marks that the ACK bit is on the bus, so the next
    // SCL fall ends the ACK slot and hands over to the following byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            ack_ph_q   <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= 2'd0;
            byte_idx_q <= 1'b0;
            cfg_q      <= G_CFG_RESET;
            tlow_q     <= 16'h4B00;
            thigh_q    <= 16'h5000;
            shadow_q   <= 12'h000;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_n;
            if (stop_det || start_det) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                ack_ph_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
                        shreg_q   <= byte_in;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (state_q == S_ADDR) begin
                                rw_q <= sda_p1;
                                if (addr_hit) begin
                                    busy_q     <= 1'b1;
                                    byte_idx_q <= 1'b0;
                                    if (sda_p1) shadow_q <= i_temperature;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_q <= byte_in[1:0];
                            end else begin
                                byte_idx_q <= ~byte_idx_q;
                                case (ptr_q)
                                    2'd1: cfg_q <= byte_in;
                                    2'd2: if (byte_idx_q) tlow_q[7:0]   <= {byte_in[7:4], 4'h0};
                                          else            tlow_q[15:8]  <= byte_in;
                                    2'd3: if (byte_idx_q) thigh_q[7:0]  <= {byte_in[7:4], 4'h0};
                                          else            thigh_q[15:8] <= byte_in;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_oe_q <= 1'b1;
                            ack_ph_q <= 1'b1;
                        end else begin
                            ack_ph_q  <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                shreg_q    <= tx_byte;
                                sda_oe_q   <= ~tx_byte[7];
                                byte_idx_q <= ~byte_idx_q;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (scl_fall) begin
                            shreg_q  <= {shreg_q[6:0], 1'b0};
                            sda_oe_q <= ~shreg_q[6];
                        end
                    end
                    S_RACK: begin
                        if (scl_fall && !ack_ph_q) sda_oe_q <= 1'b0;
                        if (scl_rise && !sda_p1)   ack_ph_q <= 1'b1;
                        if (scl_fall && ack_ph_q) begin
                            ack_ph_q   <= 1'b0;
                            bit_cnt_q  <= 3'd0;
                            shreg_q    <= tx_byte;
                            sda_oe_q   <= ~tx_byte[7];
                            byte_idx_q <= ~byte_idx_q;
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign io_sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign o_config = cfg_q;
    assign o_busy   = busy_q;
endmodule
